// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer bundle for fifo_sync_param; master drives requests, slave is the FIFO.
//   wr/rd/din in, dout/flags/count/addresses out; overflow/underflow/err_clr exist only with FIFO_ERR_EN.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
`ifdef FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
  logic              err_clr;
  modport master (output wr, rd, din, err_clr,
                  input  dout, full, empty, almost_full, almost_empty, count, w_addr, r_addr, overflow, underflow);
  modport slave  (input  wr, rd, din, err_clr,
                  output dout, full, empty, almost_full, almost_empty, count, w_addr, r_addr, overflow, underflow);
`else
  modport master (output wr, rd, din,
                  input  dout, full, empty, almost_full, almost_empty, count, w_addr, r_addr);
  modport slave  (input  wr, rd, din,
                  output dout, full, empty, almost_full, almost_empty, count, w_addr, r_addr);
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered dout, occupancy count and almost flags.
//   clk, rst (async active-low) plain ports; everything else on bus (fifo_sync_param_if.slave).
//   Define FIFO_ERR_EN to add sticky overflow/underflow flags cleared by err_clr.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input logic                clk,
  input logic                rst,
  fifo_sync_param_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE  = (ADDR_W+1)'(AE_LEVEL);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic              wr_ok, rd_ok;
  always_comb begin
    wr_ok   = bus.wr & (~full_q | bus.rd);
    rd_ok   = bus.rd & ~empty_q;
    wp_d    = wr_ok ? wp_q + ONE : wp_q;
    rp_d    = rd_ok ? rp_q + ONE : rp_q;
    cnt_d   = (wr_ok & ~rd_ok) ? cnt_q + ONE : (rd_ok & ~wr_ok) ? cnt_q - ONE : cnt_q;
    dout_d  = rd_ok ? mem[rp_q[ADDR_W-1:0]] : dout_q;
    full_d  = wp_d == {~rp_d[ADDR_W], rp_d[ADDR_W-1:0]};
    empty_d = wp_d == rp_d;
    af_d    = cnt_d >= AF;
    ae_d    = cnt_d <= AE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  // Storage is not reset; a read of the full/write-same-address case sees the old word.
  always_ff @(posedge clk)
    if (rst && wr_ok) mem[wp_q[ADDR_W-1:0]] <= bus.din;
  assign bus.dout         = dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt_q;
  assign bus.w_addr       = wp_q[ADDR_W-1:0];
  assign bus.r_addr       = rp_q[ADDR_W-1:0];
`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  always_comb begin
    ovf_d = (ovf_q & ~bus.err_clr) | (bus.wr & full_q & ~bus.rd);
    udf_d = (udf_q & ~bus.err_clr) | (bus.rd & empty_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif
endmodule
